// File: rtl/rx_decoder.sv
// 10GBASE-R receive 64b/66b block decoder: pairs 32-bit gearbox words into
// 66-bit blocks and emits two XGMII words per block, enforcing packet framing.
module rx_decoder #(
  parameter int DATA_WIDTH = 32,
  parameter int HDR_WIDTH  = 2
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic [DATA_WIDTH-1:0]   i_rx_data,
  input  logic                    i_rx_data_valid,
  input  logic [HDR_WIDTH-1:0]    i_rx_sync_hdr,
  input  logic                    i_rx_sync_hdr_valid,
  input  logic                    i_block_lock,
  output logic [DATA_WIDTH-1:0]   o_xgmii_data,
  output logic [DATA_WIDTH/8-1:0] o_xgmii_ctrl,
  output logic                    o_xgmii_valid
);

  localparam int BLK_WIDTH  = 2 * DATA_WIDTH;
  localparam int BLK_LANES  = BLK_WIDTH / 8;
  localparam int WORD_LANES = DATA_WIDTH / 8;

  localparam logic [7:0] CH_IDLE  = 8'h07;
  localparam logic [7:0] CH_START = 8'hFB;
  localparam logic [7:0] CH_TERM  = 8'hFD;
  localparam logic [7:0] CH_ERROR = 8'hFE;

  localparam logic [HDR_WIDTH-1:0] HDR_DATA = HDR_WIDTH'(2'b01);
  localparam logic [HDR_WIDTH-1:0] HDR_CTRL = HDR_WIDTH'(2'b10);

  localparam logic [DATA_WIDTH-1:0]   IDLE_WORD = {WORD_LANES{CH_IDLE}};
  localparam logic [DATA_WIDTH-1:0]   LF_WORD   = DATA_WIDTH'(32'h0100_009C);
  localparam logic [WORD_LANES-1:0]   LF_CTRL   = WORD_LANES'(4'h1);

  typedef enum logic {
    WAIT_FIRST,
    WAIT_SECOND
  } phase_t;

  typedef enum logic {
    PKT_IDLE,
    PKT_IN
  } pkt_t;

  // Framing class of a decoded block, independent of its lane contents.
  typedef enum logic [2:0] {
    K_DATA,
    K_IDLE,
    K_START,
    K_TERM,
    K_ERROR
  } kind_t;

  phase_t                  phase;
  pkt_t                    pkt_state;
  pkt_t                    pkt_next;
  logic [DATA_WIDTH-1:0]   first_word;
  logic [HDR_WIDTH-1:0]    first_hdr;
  logic                    upper_pending;
  logic [DATA_WIDTH-1:0]   upper_data;
  logic [WORD_LANES-1:0]   upper_ctrl;

  logic [BLK_WIDTH-1:0]    blk;
  logic [BLK_WIDTH-1:0]    dec_data;
  logic [BLK_LANES-1:0]    dec_ctrl;
  kind_t                   kind;
  logic [2:0]              term_k;
  logic                    violation;
  logic [BLK_WIDTH-1:0]    frame_data;
  logic [BLK_LANES-1:0]    frame_ctrl;

  function automatic logic [7:0] ctrl_code(input logic [6:0] code);
    return (code == 7'h00) ? CH_IDLE : CH_ERROR;
  endfunction

  // Block decode: lane contents and framing class, before framing checks.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // through this block leaves one unassigned and no latch is inferred.
    blk      = {i_rx_data, first_word};
    dec_data = {BLK_LANES{CH_ERROR}};
    dec_ctrl = '1;
    kind     = K_ERROR;
    term_k   = 3'd0;

    if (first_hdr == HDR_DATA) begin
      dec_data = blk;
      dec_ctrl = '0;
      kind     = K_DATA;
    end else if (first_hdr == HDR_CTRL) begin
      case (blk[7:0])
        8'h1E: begin
          kind = K_IDLE;
          for (int i = 0; i < BLK_LANES; i++) begin
            dec_data[8*i +: 8] = ctrl_code(blk[8+7*i +: 7]);
          end
        end
        8'h78: begin
          kind     = K_START;
          dec_data = {blk[BLK_WIDTH-1:8], CH_START};
          dec_ctrl = 8'h01;
        end
        8'h33: begin
          kind     = K_START;
          dec_data = {blk[BLK_WIDTH-1:40], CH_START, 32'h0};
          for (int i = 0; i < 4; i++) begin
            dec_data[8*i +: 8] = ctrl_code(blk[8+7*i +: 7]);
          end
          dec_ctrl = 8'h1F;
        end
        8'h87: begin kind = K_TERM; term_k = 3'd0; end
        8'h99: begin kind = K_TERM; term_k = 3'd1; end
        8'hAA: begin kind = K_TERM; term_k = 3'd2; end
        8'hB4: begin kind = K_TERM; term_k = 3'd3; end
        8'hCC: begin kind = K_TERM; term_k = 3'd4; end
        8'hD2: begin kind = K_TERM; term_k = 3'd5; end
        8'hE1: begin kind = K_TERM; term_k = 3'd6; end
        8'hFF: begin kind = K_TERM; term_k = 3'd7; end
        default: ;
      endcase

      // Tk: bytes 1..k shift down one lane, /T/ at lane k, idles after it.
      if (kind == K_TERM) begin
        dec_data = {BLK_LANES{CH_IDLE}};
        for (int i = 1; i < BLK_LANES; i++) begin
          if (i <= int'(term_k)) begin
            dec_data[8*(i-1) +: 8] = blk[8*i +: 8];
            dec_ctrl[i-1]          = 1'b0;
          end
        end
        dec_data[{term_k, 3'b000} +: 8] = CH_TERM;
      end
    end
  end

  // Packet framing: decide the next packet state and any error substitution.
  always_comb begin
    violation = 1'b0;
    pkt_next  = pkt_state;
    case (kind)
      K_DATA:  violation = (pkt_state == PKT_IDLE);
      K_IDLE:  violation = (pkt_state == PKT_IN);
      K_START: begin
        if (pkt_state == PKT_IN) violation = 1'b1;
        else                     pkt_next  = PKT_IN;
      end
      K_TERM: begin
        if (pkt_state == PKT_IDLE) violation = 1'b1;
        else                       pkt_next  = PKT_IDLE;
      end
      default: pkt_next = PKT_IDLE;
    endcase
    if (violation) pkt_next = PKT_IDLE;

    frame_data = violation ? {BLK_LANES{CH_ERROR}} : dec_data;
    frame_ctrl = violation ? '1 : dec_ctrl;
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // here samples the values from before this clock edge.
    if (!i_reset_n) begin
      phase         <= WAIT_FIRST;
      pkt_state     <= PKT_IDLE;
      upper_pending <= 1'b0;
      o_xgmii_data  <= IDLE_WORD;
      o_xgmii_ctrl  <= '1;
      o_xgmii_valid <= 1'b0;
      // NOTE: first_word/first_hdr/upper_* are plain holding registers; they
      // are never read unless phase or upper_pending qualify them, so they
      // carry no reset.
    end else begin
      o_xgmii_valid <= 1'b0;

      if (!i_block_lock) begin
        phase         <= WAIT_FIRST;
        pkt_state     <= PKT_IDLE;
        upper_pending <= 1'b0;
        if (i_rx_data_valid) begin
          o_xgmii_data  <= LF_WORD;
          o_xgmii_ctrl  <= LF_CTRL;
          o_xgmii_valid <= 1'b1;
        end
      end else begin
        // A block completing needs a first word in between, so the upper
        // half never coincides with a new lower half.
        if (upper_pending) begin
          o_xgmii_data  <= upper_data;
          o_xgmii_ctrl  <= upper_ctrl;
          o_xgmii_valid <= 1'b1;
          upper_pending <= 1'b0;
        end

        if (i_rx_data_valid) begin
          if (i_rx_sync_hdr_valid) begin
            first_word <= i_rx_data;
            first_hdr  <= i_rx_sync_hdr;
            phase      <= WAIT_SECOND;
          end else if (phase == WAIT_SECOND) begin
            o_xgmii_data  <= frame_data[DATA_WIDTH-1:0];
            o_xgmii_ctrl  <= frame_ctrl[WORD_LANES-1:0];
            o_xgmii_valid <= 1'b1;
            upper_data    <= frame_data[BLK_WIDTH-1:DATA_WIDTH];
            upper_ctrl    <= frame_ctrl[BLK_LANES-1:WORD_LANES];
            upper_pending <= 1'b1;
            pkt_state     <= pkt_next;
            phase         <= WAIT_FIRST;
          end
        end
      end
    end
  end

endmodule
